// File: rtl/coeff_load_ctrl_if.sv
// Coefficient stream and FIR coefficient-write port of the coefficient loader.
// The slave modport is the loader itself; master is the upstream/FIR side.
interface coeff_load_ctrl_if #(
  parameter int COEFF_WIDTH = 16,
  parameter int ADDR_WIDTH  = 6
);
  logic                   iEnSample600k;
  logic                   iLoadStart;
  logic                   iCoeffValid;
  logic [COEFF_WIDTH-1:0] iCoeffData;
  logic                   oCoeffReady;
  logic                   oCoeffUpdateFlag;
  logic [ADDR_WIDTH-1:0]  oAddrRam;
  logic [COEFF_WIDTH-1:0] oWrDtRam;
  logic                   oWrStrobe;
  logic [ADDR_WIDTH-1:0]  oNumOfCoeff;
  logic                   oBusy;
  logic                   oLoadDone;
  logic                   oLoadErr;

  modport master (
    output iEnSample600k, iLoadStart, iCoeffValid, iCoeffData,
    input  oCoeffReady, oCoeffUpdateFlag, oAddrRam, oWrDtRam, oWrStrobe,
           oNumOfCoeff, oBusy, oLoadDone, oLoadErr
  );

  modport slave (
    input  iEnSample600k, iLoadStart, iCoeffValid, iCoeffData,
    output oCoeffReady, oCoeffUpdateFlag, oAddrRam, oWrDtRam, oWrStrobe,
           oNumOfCoeff, oBusy, oLoadDone, oLoadErr
  );
endinterface

// File: rtl/coeff_load_ctrl.sv
// Loads the 17 unique FIR coefficients from a valid/ready stream into the FIR,
// starting on a sample boundary, with an idle-timeout abort.
//
// state | meaning
// IDLE  | waiting for iLoadStart
// ARM   | load requested, waiting for the next sample strobe
// LOAD  | accepting beats, one FIR write per beat, update flag high
// HOLD  | last write stable for one cycle, flag still high
module coeff_load_ctrl #(
  parameter int NUM_COEFF   = 17,
  parameter int COEFF_WIDTH = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int TIMEOUT     = 255
) (
  input logic              iClk12M,
  input logic              iRsn,
  coeff_load_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, LOAD, HOLD} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_K   = ADDR_WIDTH'(NUM_COEFF - 1);
  // Abort on the edge that closes the TIMEOUT-th consecutive idle cycle.
  localparam logic [7:0]            TMO_LAST = 8'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  k_q, k_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COEFF_WIDTH-1:0] data_q, data_d;
  logic [7:0]             tmo_q, tmo_d;
  logic                   flag_q, flag_d;
  logic                   strobe_q, strobe_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   accept;

  assign accept = (state_q == LOAD) && bus.iCoeffValid;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tmo_d    = tmo_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iLoadStart) state_d = ARM;
      end
      ARM: begin
        k_d   = '0;
        tmo_d = '0;
        if (bus.iEnSample600k) state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          addr_d   = k_q;
          data_d   = bus.iCoeffData;
          strobe_d = 1'b1;
          k_d      = k_q + 1'b1;
          tmo_d    = '0;
          if (k_q == LAST_K) state_d = HOLD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      HOLD: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    flag_d = (state_d == LOAD) || (state_d == HOLD);
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q  <= IDLE;
      k_q      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      tmo_q    <= '0;
      flag_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tmo_q    <= tmo_d;
      flag_q   <= flag_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.oCoeffReady      = (state_q == LOAD);
  assign bus.oCoeffUpdateFlag = flag_q;
  assign bus.oAddrRam         = addr_q;
  assign bus.oWrDtRam         = data_q;
  assign bus.oWrStrobe        = strobe_q;
  assign bus.oNumOfCoeff      = ADDR_WIDTH'(NUM_COEFF);
  assign bus.oBusy            = (state_q != IDLE);
  assign bus.oLoadDone        = done_q;
  assign bus.oLoadErr         = err_q;

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// Directed bench for coeff_load_ctrl: a behavioural loader model checked every
// cycle, plus literal expectations per scenario.
module tb_coeff_load_ctrl;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  always #5 clk = ~clk;

  coeff_load_ctrl_if bus ();

  coeff_load_ctrl dut (
    .iClk12M (clk),
    .iRsn    (rsn),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: phase 0=idle 1=waiting for strobe 2=loading 3=final hold
  int          m_phase, m_k, m_idle;
  logic [5:0]  m_addr;
  logic [15:0] m_data;
  logic        m_strobe, m_done, m_err;

  always @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      m_phase = 0; m_k = 0; m_idle = 0;
      m_addr = '0; m_data = '0;
      m_strobe = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_strobe = 1'b0; m_done = 1'b0; m_err = 1'b0;
      if (m_phase == 3) begin
        m_phase = 0;
        m_done  = 1'b1;
      end else if (m_phase == 2) begin
        if (bus.iCoeffValid) begin
          m_addr   = 6'(m_k);
          m_data   = bus.iCoeffData;
          m_strobe = 1'b1;
          m_idle   = 0;
          if (m_k == 16) m_phase = 3;
          m_k++;
        end else begin
          m_idle++;
          if (m_idle == 255) begin
            m_phase = 0;
            m_err   = 1'b1;
          end
        end
      end else if (m_phase == 1) begin
        if (bus.iEnSample600k) begin
          m_phase = 2; m_k = 0; m_idle = 0;
        end
      end else if (bus.iLoadStart) begin
        m_phase = 1;
      end
    end
  end

  // Per-cycle compare against the model, plus event monitors for literal checks
  int          cyc = 0;
  int          n_strobe, n_flag, n_flag_rise, n_done, n_err;
  int          strobe_cyc, done_cyc, err_cyc;
  logic        prev_flag = 1'b0;
  logic [5:0]  wq_addr[$];
  logic [15:0] wq_data[$];

  always @(negedge clk) begin
    cyc++;
    check("ready",  32'(bus.oCoeffReady),      32'(m_phase == 2));
    check("flag",   32'(bus.oCoeffUpdateFlag), 32'(m_phase == 2 || m_phase == 3));
    check("busy",   32'(bus.oBusy),            32'(m_phase != 0));
    check("strobe", 32'(bus.oWrStrobe),        32'(m_strobe));
    check("done",   32'(bus.oLoadDone),        32'(m_done));
    check("err",    32'(bus.oLoadErr),         32'(m_err));
    check("addr",   32'(bus.oAddrRam),         32'(m_addr));
    check("data",   32'(bus.oWrDtRam),         32'(m_data));
    check("numcoeff", 32'(bus.oNumOfCoeff),    32'd17);
    if (bus.oWrStrobe) begin
      n_strobe++;
      strobe_cyc = cyc;
      wq_addr.push_back(bus.oAddrRam);
      wq_data.push_back(bus.oWrDtRam);
    end
    if (bus.oCoeffUpdateFlag) n_flag++;
    if (bus.oCoeffUpdateFlag && !prev_flag) n_flag_rise++;
    prev_flag = bus.oCoeffUpdateFlag;
    if (bus.oLoadDone) begin n_done++; done_cyc = cyc; end
    if (bus.oLoadErr)  begin n_err++;  err_cyc  = cyc; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_strobe = 0; n_flag = 0; n_flag_rise = 0; n_done = 0; n_err = 0;
    strobe_cyc = 0; done_cyc = 0; err_cyc = 0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic start_and_arm(input int wait_cycles);
    bus.iLoadStart = 1'b1;
    tick();
    bus.iLoadStart = 1'b0;
    repeat (wait_cycles) tick();
    bus.iEnSample600k = 1'b1;
    tick();
    bus.iEnSample600k = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input int gap);
    bus.iCoeffValid = 1'b0;
    repeat (gap) tick();
    bus.iCoeffValid = 1'b1;
    bus.iCoeffData  = d;
    tick();
    bus.iCoeffValid = 1'b0;
  endtask

  task automatic check_writes(input string name, input logic [15:0] base);
    check({name, "_count"}, 32'(wq_addr.size()), 32'd17);
    for (int i = 0; i < wq_addr.size() && i < 17; i++) begin
      check({name, "_addr"}, 32'(wq_addr[i]), 32'(i));
      check({name, "_data"}, 32'(wq_data[i]), 32'(base + 16'(i)));
    end
  endtask

  initial begin
    bus.iEnSample600k = 1'b0;
    bus.iLoadStart    = 1'b0;
    bus.iCoeffValid   = 1'b0;
    bus.iCoeffData    = '0;
    clear_mon();

    // Reset state
    #12;
    check("rst_busy",  32'(bus.oBusy), 32'd0);
    check("rst_flag",  32'(bus.oCoeffUpdateFlag), 32'd0);
    check("rst_ready", 32'(bus.oCoeffReady), 32'd0);
    check("rst_addr",  32'(bus.oAddrRam), 32'd0);
    check("rst_data",  32'(bus.oWrDtRam), 32'd0);
    tick();
    rsn = 1'b1;
    repeat (2) tick();

    // Nominal back-to-back load
    clear_mon();
    start_and_arm(6);
    for (int k = 0; k < 17; k++) send_beat(16'h0100 + 16'(k), 0);
    repeat (5) tick();
    check("nom_strobes", 32'(n_strobe), 32'd17);
    check("nom_flag_cycles", 32'(n_flag), 32'd18);
    check("nom_done", 32'(n_done), 32'd1);
    check("nom_err", 32'(n_err), 32'd0);
    check("nom_done_after_last", 32'(done_cyc - strobe_cyc), 32'd1);
    check_writes("nom", 16'h0100);

    // Gaps of k%11 idle cycles before each beat
    clear_mon();
    start_and_arm(3);
    for (int k = 0; k < 17; k++) send_beat(16'h3000 + 16'(k), k % 11);
    repeat (5) tick();
    check("gap_flag_cycles", 32'(n_flag), 32'd88);
    check("gap_flag_rises", 32'(n_flag_rise), 32'd1);
    check("gap_done", 32'(n_done), 32'd1);
    check("gap_done_after_last", 32'(done_cyc - strobe_cyc), 32'd1);
    check_writes("gap", 16'h3000);

    // Timeout after 4 beats
    clear_mon();
    start_and_arm(2);
    for (int k = 0; k < 4; k++) send_beat(16'h5000 + 16'(k), 0);
    repeat (300) tick();
    check("tmo_strobes", 32'(n_strobe), 32'd4);
    check("tmo_err", 32'(n_err), 32'd1);
    check("tmo_done", 32'(n_done), 32'd0);
    check("tmo_err_delay", 32'(err_cyc - strobe_cyc), 32'd255);
    check("tmo_flag_low", 32'(bus.oCoeffUpdateFlag), 32'd0);
    check("tmo_busy_low", 32'(bus.oBusy), 32'd0);

    // Retrigger during ARM and LOAD, stray strobe during LOAD
    clear_mon();
    bus.iLoadStart = 1'b1;
    tick();
    bus.iLoadStart = 1'b1;
    tick();
    bus.iLoadStart = 1'b0;
    repeat (2) tick();
    bus.iEnSample600k = 1'b1;
    tick();
    bus.iEnSample600k = 1'b0;
    for (int k = 0; k < 17; k++) begin
      bus.iLoadStart    = (k == 3);
      bus.iEnSample600k = (k == 6);
      send_beat(16'h7000 + 16'(k), 0);
    end
    bus.iLoadStart    = 1'b0;
    bus.iEnSample600k = 1'b0;
    repeat (4) tick();
    check("rtg_strobes", 32'(n_strobe), 32'd17);
    check("rtg_done", 32'(n_done), 32'd1);
    check("rtg_idle_after", 32'(bus.oBusy), 32'd0);
    check_writes("rtg", 16'h7000);
    clear_mon();
    start_and_arm(4);
    for (int k = 0; k < 17; k++) send_beat(16'h0200 + 16'(k), 0);
    repeat (4) tick();
    check("rtg2_done", 32'(n_done), 32'd1);
    check_writes("rtg2", 16'h0200);

    // ARM gating: valid held before the strobe
    clear_mon();
    bus.iLoadStart = 1'b1;
    tick();
    bus.iLoadStart  = 1'b0;
    bus.iCoeffValid = 1'b1;
    bus.iCoeffData  = 16'hA000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("arm_ready_low", 32'(bus.oCoeffReady), 32'd0);
    end
    check("arm_no_accept", 32'(n_strobe), 32'd0);
    bus.iEnSample600k = 1'b1;
    tick();
    bus.iEnSample600k = 1'b0;
    check("arm_ready_high", 32'(bus.oCoeffReady), 32'd1);
    for (int k = 0; k < 17; k++) send_beat(16'hA000 + 16'(k), 0);
    repeat (4) tick();
    check("arm_done", 32'(n_done), 32'd1);
    check_writes("arm", 16'hA000);

    // Asynchronous reset mid-load at k=5
    clear_mon();
    start_and_arm(1);
    for (int k = 0; k < 5; k++) send_beat(16'hC000 + 16'(k), 0);
    check("rst_mid_k", 32'(n_strobe), 32'd4);
    bus.iCoeffValid = 1'b0;
    #2 rsn = 1'b0;
    #1;
    check("mid_rst_busy",   32'(bus.oBusy), 32'd0);
    check("mid_rst_flag",   32'(bus.oCoeffUpdateFlag), 32'd0);
    check("mid_rst_ready",  32'(bus.oCoeffReady), 32'd0);
    check("mid_rst_strobe", 32'(bus.oWrStrobe), 32'd0);
    check("mid_rst_done",   32'(bus.oLoadDone), 32'd0);
    check("mid_rst_err",    32'(bus.oLoadErr), 32'd0);
    check("mid_rst_addr",   32'(bus.oAddrRam), 32'd0);
    check("mid_rst_data",   32'(bus.oWrDtRam), 32'd0);
    tick();
    rsn = 1'b1;
    clear_mon();
    bus.iCoeffValid = 1'b1;
    bus.iCoeffData  = 16'hC005;
    repeat (10) tick();
    bus.iCoeffValid = 1'b0;
    check("post_rst_strobes", 32'(n_strobe), 32'd0);
    check("post_rst_busy", 32'(bus.oBusy), 32'd0);
    check("post_rst_ready", 32'(bus.oCoeffReady), 32'd0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coeff_load_ctrl.md
# coeff_load_ctrl

Coefficient load controller that sits directly upstream of the 33-tap symmetric FIR top and drives its coefficient-update port. It accepts the 17 unique coefficients (h0..h16) over a valid/ready stream and schedules the load to start on a sample boundary. It then presents one address/data write per coefficient with the update flag held, and reports completion or timeout. The FIR's own FSM splits address k into even-tap (RAM1) and odd-tap (RAM2) storage.

## Interface

- NUM_COEFF, 17, unique coefficients per set (33 taps, symmetric)
- COEFF_WIDTH, 16, coefficient width
- ADDR_WIDTH, 6, FIR coefficient address width
- TIMEOUT, 255, max idle cycles between accepted beats in LOAD (8-bit counter)

Ports:

- iClk12M  in  1  system clock, 12 MHz
- iRsn  in  1  reset; asynchronous, active-low
- iEnSample600k  in  1  one-cycle sample strobe, every 20 clocks
- iLoadStart  in  1  one-cycle request to load a new set
- iCoeffValid  in  1  stream beat valid
- iCoeffData  in  COEFF_WIDTH  coefficient h[k], sent in order k=0..NUM_COEFF-1
- oCoeffReady  out  1  stream ready
- oCoeffUpdateFlag  out  1  to FIR iCoeffUpdateFlag; high for the whole load
- oAddrRam  out  ADDR_WIDTH  to FIR iAddrRam; coefficient index k
- oWrDtRam  out  COEFF_WIDTH  to FIR iWrDtRam
- oWrStrobe  out  1  one-cycle marker that oAddrRam/oWrDtRam carry a new write
- oNumOfCoeff  out  ADDR_WIDTH  to FIR iNumOfCoeff; constant NUM_COEFF
- oBusy  out  1  high in any state except IDLE
- oLoadDone  out  1  one-cycle pulse on successful completion
- oLoadErr  out  1  one-cycle pulse on timeout abort

## Operation

- States: IDLE, ARM, LOAD, HOLD.
- IDLE: if iLoadStart=1, go to ARM. Otherwise stay in IDLE.
- ARM: wait for iEnSample600k=1, then go to LOAD. Clear the index k and the timeout counter.
- LOAD:
  - oCoeffReady=1.
  - Accept a beat when iCoeffValid and oCoeffReady are both 1. On accept, register oAddrRam=k and oWrDtRam=iCoeffData, pulse oWrStrobe, increment k, and clear the timeout counter.
  - If no beat is accepted in a cycle, increment the timeout counter.
  - On accepting beat k=NUM_COEFF-1, go to HOLD.
  - If the counter reaches TIMEOUT, abort: pulse oLoadErr and go to IDLE.
- HOLD: single cycle with the flag still high and the last address/data stable. Then pulse oLoadDone and go to IDLE.
- oCoeffUpdateFlag is registered: high in LOAD and HOLD, low otherwise. On abort it drops together with the state change.
- iLoadStart while oBusy=1 is ignored; it is not queued.
- iEnSample600k in LOAD or HOLD has no effect on the loader. The FIR FSM suspends filtering while the flag is high.
- oNumOfCoeff is tied to NUM_COEFF (6'd17).
- Coefficient data passes through unmodified; there is no sign or width conversion.

## Timing

- Reset values:
  - state=IDLE.
  - oCoeffReady, oCoeffUpdateFlag, oWrStrobe, oBusy, oLoadDone, oLoadErr = 0.
  - oAddrRam=0, oWrDtRam=0.
  - k=0, timeout counter=0.
- oCoeffReady is decoded from the state register, with no combinational path from iCoeffValid.
- iLoadStart at edge N: oBusy=1 at N+1.
- Strobe seen in ARM at edge S: flag and ready are high from S+1.
- Beat accepted at edge A: oAddrRam/oWrDtRam/oWrStrobe are valid from A+1 for one cycle; address/data hold until the next accept.
- Last beat accepted at edge L:
  - ready=0 from L+1;
  - HOLD at L+1;
  - oLoadDone=1 and flag=0 at L+2;
  - oBusy=0 at L+2.
- With back-to-back beats, a full load takes 17 beat cycles plus 1 HOLD cycle, i.e. 18 cycles of flag high. This fits inside one 20-cycle sample period.
- Timeout: TIMEOUT consecutive non-accept cycles in LOAD cause an abort on the next edge, with oLoadErr high for one cycle. Partial writes remain in the FIR RAM, and the system must reload.
- Asynchronous reset mid-load clears all outputs immediately and returns to IDLE; the load is not resumed.

## Test plan

- Reset: assert iRsn=0 mid-LOAD (k=5) -> all outputs 0 immediately; after release, oBusy=0 and iCoeffValid is ignored.
- Nominal load:
  - Stimulus: pulse iLoadStart, then iEnSample600k 7 cycles later; stream h[k]=16'h0100+k with valid always high.
  - Response: 17 oWrStrobe pulses, with addresses 0..16 and data 16'h0100..16'h0110 in order.
  - Response: flag high for exactly 18 cycles, then a single oLoadDone pulse.
- Backpressure/gaps: insert idle cycles of valid (up to 10 per beat) -> writes are still in order and the flag stays high continuously; oLoadDone fires only after address 16.
- Timeout: stop valid after 4 beats -> oLoadErr pulses after exactly 255 idle cycles, the flag drops, and oLoadDone never pulses.
- Retrigger: pulse iLoadStart during ARM and again during LOAD -> exactly one load occurs; then a fresh iLoadStart in IDLE starts a second, complete load.
- ARM gating: hold valid high before the strobe -> no beat is accepted and oCoeffReady=0 until the cycle after iEnSample600k.
